// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU memory stage and a 64-bit RAM port; narrow stores use read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned requests answer with an error and touch no RAM.
module mem_access_unit #(
  parameter int MEM_SIZE = 524288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [2:0]  ram_state,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic        ram_write_en,
  input  logic [63:0] ram_rdata,
  input  logic        ram_error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [63:0] LAST_DW_ADDR = 64'(MEM_SIZE) - 64'd8;
  localparam logic [2:0]  RAM_ST_IDLE  = 3'b000;
  localparam logic [2:0]  RAM_ST_WRITE = 3'b100;

  function automatic logic [63:0] load_extend(input logic [63:0] d, input logic [1:0] sz,
                                              input logic sg);
    logic [63:0] r;
    case (sz)
      2'd0:    r = {{56{sg & d[7]}}, d[7:0]};
      2'd1:    r = {{48{sg & d[15]}}, d[15:0]};
      2'd2:    r = {{32{sg & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] old_d, input logic [63:0] new_d,
                                              input logic [1:0] sz);
    logic [63:0] r;
    case (sz)
      2'd0:    r = {old_d[63:8], new_d[7:0]};
      2'd1:    r = {old_d[63:16], new_d[15:0]};
      2'd2:    r = {old_d[63:32], new_d[31:0]};
      default: r = new_d;
    endcase
    return r;
  endfunction

  // Same bound the RAM applies; lets a dword store decide its write enable before WRITE begins.
  function automatic logic in_range(input logic [63:0] a);
    return (a <= LAST_DW_ADDR);
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [63:0] a, input logic [1:0] sz);
    logic r;
    case (sz)
      2'd1:    r = a[0];
      2'd2:    r = |a[1:0];
      2'd3:    r = |a[2:0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  state_t      state_r, next_state_s;
  logic [1:0]  size_r;
  logic        signed_r;
  logic [63:0] wdata_r;
  logic        accept_s;
  logic        misalign_s;

  logic        resp_valid_r, resp_valid_s;
  logic [63:0] resp_rdata_r, resp_rdata_s;
  logic        resp_error_r, resp_error_s;
  logic [2:0]  ram_state_r, ram_state_s;
  logic [63:0] ram_addr_r, ram_addr_s;
  logic [63:0] ram_wdata_r, ram_wdata_s;
  logic        ram_we_r, ram_we_s;

  assign req_ready = (state_r == ST_IDLE) & ~reset;
  assign accept_s  = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = misaligned(req_addr, req_size);
`else
  assign misalign_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (misalign_s) begin
            next_state_s = ST_RESP;
          end else if (!req_write) begin
            next_state_s = ST_LOAD;
          end else if (req_size == 2'd3) begin
            next_state_s = ST_WRITE;
          end else begin
            next_state_s = ST_MERGE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD:  next_state_s = ST_RESP;
      ST_MERGE: next_state_s = ram_error ? ST_RESP : ST_WRITE;
      ST_WRITE: next_state_s = ST_RESP;
      ST_RESP:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; response fields hold outside the pulse.
  always_comb begin
    resp_valid_s = 1'b0;
    resp_rdata_s = resp_rdata_r;
    resp_error_s = resp_error_r;
    ram_state_s  = RAM_ST_IDLE;
    ram_we_s     = 1'b0;
    ram_addr_s   = ram_addr_r;
    ram_wdata_s  = ram_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          ram_addr_s = req_addr;
          if (misalign_s) begin
            resp_valid_s = 1'b1;
            resp_rdata_s = 64'd0;
            resp_error_s = 1'b1;
          end else if (req_write && (req_size == 2'd3)) begin
            ram_wdata_s = req_wdata;
            ram_we_s    = in_range(req_addr);
            ram_state_s = in_range(req_addr) ? RAM_ST_WRITE : RAM_ST_IDLE;
          end else begin
            ram_wdata_s = ram_wdata_r;
          end
        end else begin
          ram_addr_s = ram_addr_r;
        end
      end
      ST_LOAD: begin
        resp_valid_s = 1'b1;
        if (ram_error) begin
          resp_rdata_s = 64'd0;
          resp_error_s = 1'b1;
        end else begin
          resp_rdata_s = load_extend(ram_rdata, size_r, signed_r);
          resp_error_s = 1'b0;
        end
      end
      ST_MERGE: begin
        if (ram_error) begin
          resp_valid_s = 1'b1;
          resp_rdata_s = 64'd0;
          resp_error_s = 1'b1;
        end else begin
          ram_wdata_s = store_merge(ram_rdata, wdata_r, size_r);
          ram_we_s    = 1'b1;
          ram_state_s = RAM_ST_WRITE;
        end
      end
      ST_WRITE: begin
        resp_valid_s = 1'b1;
        resp_rdata_s = 64'd0;
        resp_error_s = ram_error;
      end
      ST_RESP: begin
        resp_valid_s = 1'b0;
      end
      default: begin
        resp_valid_s = 1'b0;
      end
    endcase
  end

  // Request fields and registered outputs; reset drops the write enable asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_r       <= 2'd0;
      signed_r     <= 1'b0;
      wdata_r      <= 64'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 64'd0;
      resp_error_r <= 1'b0;
      ram_state_r  <= RAM_ST_IDLE;
      ram_addr_r   <= 64'd0;
      ram_wdata_r  <= 64'd0;
      ram_we_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        size_r   <= req_size;
        signed_r <= req_signed;
        wdata_r  <= req_wdata;
      end
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_error_r <= resp_error_s;
      ram_state_r  <= ram_state_s;
      ram_addr_r   <= ram_addr_s;
      ram_wdata_r  <= ram_wdata_s;
      ram_we_r     <= ram_we_s;
    end
  end

  assign resp_valid   = resp_valid_r;
  assign resp_rdata   = resp_rdata_r;
  assign resp_error   = resp_error_r;
  assign ram_state    = ram_state_r;
  assign ram_addr     = ram_addr_r;
  assign ram_wdata    = ram_wdata_r;
  assign ram_write_en = ram_we_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array RAM plus a byte-level reference model.
module tb_mem_access_unit;
  localparam int MEM = 4096;
  localparam logic [63:0] LAST = 64'(MEM - 8);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [2:0]  ram_state;
  logic [63:0] ram_addr;
  logic [63:0] ram_wdata;
  logic        ram_write_en;
  logic [63:0] ram_rdata;
  logic        ram_error;

  logic [7:0] ram_mem [0:MEM-1];
  logic [7:0] mdl_mem [0:MEM-1];

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int we_count = 0;
  int bad_state = 0;

  mem_access_unit #(.MEM_SIZE(MEM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_state(ram_state), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_write_en(ram_write_en), .ram_rdata(ram_rdata), .ram_error(ram_error)
  );

  always #5 clk = ~clk;

  assign ram_error = (ram_addr > LAST);

  // RAM commit at the clock edge ending the write cycle
  always @(posedge clk) begin
    if (ram_write_en && (ram_state == 3'b100) && (ram_addr <= LAST)) begin
      for (int i = 0; i < 8; i++) ram_mem[ram_addr[11:0] + 12'(i)] <= ram_wdata[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    if (ram_addr <= LAST) begin
      for (int i = 0; i < 8; i++) ram_rdata[8*i +: 8] <= ram_mem[ram_addr[11:0] + 12'(i)];
    end else begin
      ram_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  always @(posedge clk) if (ram_write_en) we_count <= we_count + 1;
  always @(negedge clk) if (ram_write_en !== (ram_state == 3'b100)) bad_state <= bad_state + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er);
    int n, exp_cyc, exp_we, we_base, cyc, pulses;
    logic misal, exp_err, rdy;
    logic [63:0] exp_rd;
    n = 1 << sz;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = ((a % 64'(n)) != 64'd0);
`else
    misal = 1'b0;
`endif
    exp_err = misal || (a > LAST);
    exp_cyc = misal ? 1 : ((w && sz != 2'd3 && !exp_err) ? 3 : 2);
    exp_we  = (w && !exp_err) ? 1 : 0;
    exp_rd  = 64'd0;
    if (!w && !exp_err) begin
      for (int i = 0; i < n; i++) exp_rd = exp_rd | (64'(mdl_mem[a[11:0] + 12'(i)]) << (8*i));
      if (sg && n < 8 && exp_rd[8*n-1]) exp_rd = exp_rd | ~((64'd1 << (8*n)) - 64'd1);
    end
    @(negedge clk);
    check("ready_idle", {63'd0, req_ready}, 64'd1);
    we_base = we_count;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0; pulses = 0; rd = 64'd0; er = 1'b0; rdy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (resp_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          cyc = k; rd = resp_rdata; er = resp_error; rdy = req_ready;
        end
      end
    end
    check("resp_cycle", 64'(cyc), 64'(exp_cyc));
    check("resp_pulses", 64'(pulses), 64'd1);
    check("resp_rdata", rd, exp_rd);
    check("resp_error", {63'd0, er}, {63'd0, exp_err});
    check("ready_in_resp", {63'd0, rdy}, 64'd0);
    check("write_cycles", 64'(we_count - we_base), 64'(exp_we));
    if (w && !exp_err) begin
      for (int i = 0; i < n; i++) mdl_mem[a[11:0] + 12'(i)] = wd[8*i +: 8];
    end
  endtask

  initial begin
    logic [63:0] rd, a;
    logic er;
    int pulses, we_base, mism;

    #2;
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_error", {63'd0, resp_error}, 64'd0);
    check("rst_ram_state", {61'd0, ram_state}, 64'd0);
    check("rst_ram_we", {63'd0, ram_write_en}, 64'd0);
    check("rst_ram_addr", ram_addr, 64'd0);
    check("rst_ram_wdata", ram_wdata, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // preload the low window and the top dwords through the unit
    for (int i = 0; i < 1024; i += 8) do_req(1'b1, 2'd3, 1'b0, 64'(i), {$urandom, $urandom}, rd, er);
    for (int i = MEM - 64; i <= MEM - 8; i += 8)
      do_req(1'b1, 2'd3, 1'b0, 64'(i), {$urandom, $urandom}, rd, er);

    do_req(1'b1, 2'd3, 1'b0, 64'h100, 64'h1122334455667788, rd, er);
    check("dw_store_ok", {63'd0, er}, 64'd0);
    do_req(1'b0, 2'd3, 1'b0, 64'h100, 64'd0, rd, er);
    check("dw_load", rd, 64'h1122334455667788);
    do_req(1'b1, 2'd0, 1'b0, 64'h101, 64'h0000_0000_0000_00AB, rd, er);
    do_req(1'b0, 2'd3, 1'b0, 64'h100, 64'd0, rd, er);
    check("byte_merge", rd, 64'h112233445566AB88);
    do_req(1'b0, 2'd0, 1'b1, 64'h101, 64'd0, rd, er);
    check("byte_signed", rd, 64'hFFFFFFFFFFFFFFAB);
    do_req(1'b0, 2'd0, 1'b0, 64'h101, 64'd0, rd, er);
    check("byte_unsigned", rd, 64'h00000000000000AB);
    do_req(1'b0, 2'd1, 1'b1, 64'h106, 64'd0, rd, er);
    check("half_signed_pos", rd, 64'h0000000000001122);
    do_req(1'b1, 2'd2, 1'b0, 64'h200, 64'h0000_0000_8000_0000, rd, er);
    do_req(1'b0, 2'd2, 1'b1, 64'h200, 64'd0, rd, er);
    check("word_signed_neg", rd, 64'hFFFFFFFF80000000);

    do_req(1'b0, 2'd0, 1'b0, 64'(MEM - 7), 64'd0, rd, er);
    check("edge_load_err", {63'd0, er}, 64'd1);
    do_req(1'b1, 2'd0, 1'b0, 64'(MEM - 7), 64'h55, rd, er);
    check("edge_bstore_err", {63'd0, er}, 64'd1);
    do_req(1'b1, 2'd3, 1'b0, 64'(MEM - 7), 64'h0123_4567_89AB_CDEF, rd, er);
    do_req(1'b0, 2'd3, 1'b0, 64'(MEM - 8), 64'd0, rd, er);
    check("last_dw_ok", {63'd0, er}, 64'd0);
    do_req(1'b0, 2'd0, 1'b1, 64'(MEM - 1), 64'd0, rd, er);
    do_req(1'b1, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1234_5678, rd, er);

    do_req(1'b1, 2'd1, 1'b0, 64'h103, 64'h0000_0000_0000_CDEF, rd, er);
    do_req(1'b0, 2'd3, 1'b0, 64'h100, 64'd0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    check("misal_half_store", rd, 64'h112233445566AB88);
`else
    check("misal_half_store", rd, 64'h112233CDEF66AB88);
`endif

    // reset during the WRITE cycle of a byte store
    @(negedge clk);
    we_base = we_count;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 64'h300; req_wdata = 64'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstw_we_high", {63'd0, ram_write_en}, 64'd1);
    #1 reset = 1'b1;
    #1 check("rstw_we_async", {63'd0, ram_write_en}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rstw_ready", {63'd0, req_ready}, 64'd1);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid === 1'b1) pulses++;
    end
    check("rstw_no_resp", 64'(pulses), 64'd0);
    check("rstw_no_write", 64'(we_count - we_base), 64'd0);
    do_req(1'b0, 2'd0, 1'b0, 64'h300, 64'd0, rd, er);

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 9) == 0) a = 64'(MEM - 16) + 64'($urandom_range(0, 15));
      else a = 64'($urandom_range(0, 1016));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom}, rd, er);
    end

    mism = 0;
    for (int i = 0; i < MEM; i++) if (ram_mem[i] !== mdl_mem[i]) mism++;
    check("mem_image", 64'(mism), 64'd0);
    check("we_state_consistent", 64'(bad_state), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
